ahb_sub_responder: RTL and testbench
====================================

AHB_SUB_RESPONDER -- requirements
Module: ahb_sub_responder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, named HCLK and HRESETn.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the HADDR width in bits.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the HWDATA/HRDATA width and SHALL be 32 or 64.
REQ-004 Parameter MEM_WORDS, default 256, SHALL set the number of DATA_WIDTH-wide storage words (power of two).
REQ-005 The ports SHALL be, in order:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  subordinate select
- HADDR  in  ADDR_WIDTH  address-phase address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size, bytes=2^HSIZE
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus-level ready, from the multiplexor
- wait_cfg  in  4  wait states to insert; sampled at address-phase accept
- HRDATA  out  DATA_WIDTH  read data
- HREADYOUT  out  1  this subordinate's ready
- HRESP  out  1  0=OKAY, 1=ERROR

Function
REQ-006 A transfer SHALL be accepted at a rising HCLK edge where HSEL=1, HTRANS[1]=1 and HREADY=1; the module SHALL then capture HADDR, HWRITE, HSIZE and wait_cfg.
REQ-007 When HSEL=0, or HTRANS is IDLE or BUSY, with HREADY=1, the module SHALL stay in IDLE and drive a zero-wait OKAY.
REQ-008 The FSM SHALL have four states:
- IDLE: HREADYOUT=1, HRESP=0.
- WAIT: HREADYOUT=0, HRESP=0.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
REQ-009 On an accepted transfer, the next state SHALL be:
- ERR1 if it is an error transfer (REQ-015);
- WAIT if wait_cfg>0, with a down-counter loaded with wait_cfg;
- otherwise IDLE, completing with zero waits.
REQ-010 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL return to IDLE after exactly wait_cfg cycles with HREADYOUT=0.
REQ-011 ERR1 SHALL always go to ERR2, and ERR2 SHALL always go to IDLE.
REQ-012 The data phase SHALL complete in the first cycle with HREADYOUT=1 after acceptance. In that cycle, the module SHALL accept a new address phase under REQ-006 (pipelined back-to-back transfers).
REQ-013 Writes SHALL update only the byte lanes selected by HSIZE and captured HADDR[log2(DATA_WIDTH/8)-1:0], using HWDATA sampled at the completing edge.
REQ-014 HRDATA SHALL carry the full addressed word during a completing read data-phase cycle and SHALL be 0 otherwise.
- A read in the data phase immediately after a write to the same word SHALL return the newly written data.
REQ-015 An error transfer SHALL be one whose word index (captured HADDR / (DATA_WIDTH/8)) is >= MEM_WORDS, or whose 2^HSIZE exceeds DATA_WIDTH/8.
- Error writes SHALL NOT modify memory.
- Error reads SHALL return HRDATA=0.
REQ-016 A transfer accepted in ERR2 SHALL be processed normally. An IDLE driven during ERR2 (manager cancel) SHALL leave the FSM in IDLE.
REQ-017 wait_cfg changes SHALL affect only subsequently accepted transfers.

Reset
REQ-018 While HRESETn=0, the module SHALL hold state IDLE, counter=0, HREADYOUT=1, HRESP=0 and HRDATA=0.
REQ-019 Reset asserted mid-WAIT or mid-ERR1/ERR2 SHALL abort the transfer with no memory write; memory contents SHALL NOT be cleared by reset.
REQ-020 After reset deassertion, the first acceptable edge SHALL accept a transfer.

Configuration
REQ-021 With AHB_SUB_ERR_RESP_EN defined, REQ-015 SHALL apply.
REQ-022 Without AHB_SUB_ERR_RESP_EN:
- ERR1/ERR2 SHALL be unreachable;
- out-of-range word indices SHALL wrap modulo MEM_WORDS;
- oversized HSIZE SHALL be treated as full-word access;
- HRESP SHALL be constant 0.

Verification
REQ-023 Write 0xDEADBEEF to 0x10 (HSIZE=2, wait_cfg=0), then read 0x10 -> each data phase completes in 1 cycle and HRDATA=0xDEADBEEF, HRESP=0.
REQ-024 Read 0x20 with wait_cfg=3 -> HREADYOUT low for exactly 3 cycles, then high with data and HRESP=0.
REQ-025 Byte write 0xAA to 0x13 (HSIZE=0) over word 0x11223344, then read 0x10 -> HRDATA=0xAA223344.
REQ-026 With the macro defined, write to 0x400 (MEM_WORDS=256, 32-bit) -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), with memory unchanged. Without the macro, the same write -> OKAY and lands at 0x000.
REQ-027 Back-to-back NONSEQ write 0x0 then read 0x0 with wait_cfg=0 -> the read returns the written value with no extra cycle.
REQ-028 HRESETn pulsed low during the second of 4 wait states of a write -> HREADYOUT=1 immediately and the target word is unchanged.

Source files
------------

// File: rtl/ahb_sub_responder.sv
// ---------------------------------------------------------------------------
// ahb_sub_responder
//
// Purpose:
//   AHB-Lite subordinate with a small word-addressed memory and a
//   configurable number of wait states per transfer. Reads return the full
//   addressed word. Writes update only the byte lanes selected by the
//   transfer size and low address bits. Address and data phases are
//   pipelined, so back-to-back transfers complete without idle cycles.
//
// Configuration macro:
//   AHB_SUB_ERR_RESP_EN
//     defined   : out-of-range word indices and oversized HSIZE produce a
//                 two-cycle ERROR response. Memory is untouched and read
//                 data is zero.
//     undefined : no ERROR response. Out-of-range indices wrap modulo
//                 MEM_WORDS, oversized HSIZE acts as a full-word access,
//                 and HRESP is tied to OKAY.
//
// Parameters:
//   ADDR_WIDTH  HADDR width in bits
//   DATA_WIDTH  HWDATA/HRDATA width in bits (32 or 64)
//   MEM_WORDS   number of DATA_WIDTH-wide storage words (power of two)
//
// Ports:
//   HCLK       in   bus clock
//   HRESETn    in   asynchronous active-low reset
//   HSEL       in   subordinate select
//   HADDR      in   address-phase address
//   HTRANS     in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE     in   1 = write
//   HSIZE      in   transfer size, bytes = 2^HSIZE
//   HWDATA     in   write data, valid in the data phase
//   HREADY     in   bus-level ready from the multiplexor
//   wait_cfg   in   wait states to insert, sampled when a transfer is accepted
//   HRDATA     out  read data, zero outside a completing read
//   HREADYOUT  out  this subordinate's ready
//   HRESP      out  0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
module ahb_sub_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 256
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   input  logic [3:0]            wait_cfg,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int BYTES     = DATA_WIDTH / 8;
   localparam int LANE_BITS = $clog2(BYTES);
   localparam int IDX_BITS  = $clog2(MEM_WORDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ERR1 = 2'd2;
   localparam logic [1:0] S_ERR2 = 2'd3;

   logic [1:0]            r_state;
   logic [3:0]            r_waitCnt;
   logic                  r_pending;
   logic                  r_write;
   logic                  r_err;
   logic [IDX_BITS-1:0]   r_wordIdx;
   logic [BYTES-1:0]      r_laneMask;
   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

   logic                  w_ready;
   logic                  w_accept;
   logic                  w_complete;
   logic                  w_oversize;
   logic                  w_addrErr;
   logic [2:0]            w_effSize;
   logic [BYTES-1:0]      w_laneMask;
   logic                  w_unused;

   // IDLE and ERR2 are the only states that drive HREADYOUT high. A pending
   // data phase finishes in whichever of these comes first after acceptance.
   assign w_ready    = (r_state == S_IDLE) || (r_state == S_ERR2);
   assign w_accept   = HSEL && HTRANS[1] && HREADY && w_ready;
   assign w_complete = r_pending && w_ready;

   assign w_oversize = (HSIZE > 3'(LANE_BITS));
   assign w_effSize  = w_oversize ? 3'(LANE_BITS) : HSIZE;

`ifdef AHB_SUB_ERR_RESP_EN
   logic w_outOfRange;
   assign w_outOfRange = (HADDR >> (LANE_BITS + IDX_BITS)) != '0;
   assign w_addrErr    = w_outOfRange || w_oversize;
   assign HRESP        = (r_state == S_ERR1) || (r_state == S_ERR2);
`else
   assign w_addrErr    = 1'b0;
   assign HRESP        = 1'b0;
`endif

   // HTRANS[0] (SEQ vs NONSEQ) does not change behaviour. The upper address
   // bits are ignored when indices wrap.
   assign w_unused = &{1'b0, HTRANS[0], HADDR};

   // Byte lanes touched by the transfer: size-aligned group starting at the
   // low address bits.
   always_comb begin : laneDecode
      int unsigned nBytes;
      int unsigned base;
      w_laneMask = '0;
      nBytes     = 32'd1 << w_effSize;
      base       = 32'(HADDR[LANE_BITS-1:0]) & ~(nBytes - 32'd1);
      for (int b = 0; b < BYTES; b++) begin
         if ((unsigned'(b) >= base) && (unsigned'(b) < base + nBytes))
            w_laneMask[b] = 1'b1;
      end
   end

   // Response FSM and captured address-phase information. A new transfer is
   // accepted in the same cycle the previous data phase completes.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state    <= S_IDLE;
         r_waitCnt  <= '0;
         r_pending  <= 1'b0;
         r_write    <= 1'b0;
         r_err      <= 1'b0;
         r_wordIdx  <= '0;
         r_laneMask <= '0;
      end else begin
         case (r_state)
            S_WAIT: begin
               r_waitCnt <= r_waitCnt - 4'd1;
               if (r_waitCnt == 4'd1)
                  r_state <= S_IDLE;
            end
            S_ERR1: r_state <= S_ERR2;
            default: begin
               if (w_accept && w_addrErr) begin
                  r_state <= S_ERR1;
               end else if (w_accept && (wait_cfg != 4'd0)) begin
                  r_state   <= S_WAIT;
                  r_waitCnt <= wait_cfg;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase

         if (w_accept) begin
            r_pending  <= 1'b1;
            r_write    <= HWRITE;
            r_err      <= w_addrErr;
            r_wordIdx  <= HADDR[LANE_BITS +: IDX_BITS];
            r_laneMask <= w_laneMask;
         end else if (w_complete) begin
            r_pending <= 1'b0;
         end
      end
   end

   // Storage has no reset, so its contents survive HRESETn. A write lands
   // only on the completing edge of a non-error data phase. Reset clears
   // r_pending, so an aborted transfer never writes.
   always_ff @(posedge HCLK) begin
      if (w_complete && r_write && !r_err) begin
         for (int b = 0; b < BYTES; b++) begin
            if (r_laneMask[b])
               r_mem[r_wordIdx][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   assign HREADYOUT = w_ready;
   assign HRDATA    = (w_complete && !r_write && !r_err) ? r_mem[r_wordIdx] : '0;

endmodule

// File: tb/tb_ahb_sub_responder.sv
// ---------------------------------------------------------------------------
// tb_ahb_sub_responder
//
// Self-checking bench for ahb_sub_responder (32-bit data, 256 words).
// A transaction-level model tracks the one outstanding data phase as
// "cycles elapsed / cycles it must last". It also keeps a byte-lane memory
// image. Every cycle, the DUT outputs are compared against what that model
// predicts. Directed sequences pin the model with literal values, and then
// randomized traffic follows, including reset pulses.
// ---------------------------------------------------------------------------
module tb_ahb_sub_responder;

   localparam int MEM_WORDS = 256;
`ifdef AHB_SUB_ERR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        HCLK     = 1'b0;
   logic        HRESETn  = 1'b0;
   logic        HSEL     = 1'b0;
   logic [31:0] HADDR    = '0;
   logic [1:0]  HTRANS   = '0;
   logic        HWRITE   = 1'b0;
   logic [2:0]  HSIZE    = '0;
   logic [31:0] HWDATA   = '0;
   logic [3:0]  wait_cfg = '0;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   int nTests = 0;
   int nFail  = 0;

   // Single subordinate on the bus: the multiplexor ready is our own ready.
   assign HREADY = HREADYOUT;

   always #5 HCLK = ~HCLK;

   ahb_sub_responder #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .MEM_WORDS (MEM_WORDS)
   ) dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .HSEL     (HSEL),
      .HADDR    (HADDR),
      .HTRANS   (HTRANS),
      .HWRITE   (HWRITE),
      .HSIZE    (HSIZE),
      .HWDATA   (HWDATA),
      .HREADY   (HREADY),
      .wait_cfg (wait_cfg),
      .HRDATA   (HRDATA),
      .HREADYOUT(HREADYOUT),
      .HRESP    (HRESP)
   );

   // ---------------- behavioural model ----------------
   bit [31:0] modelMem [MEM_WORDS];
   bit        phValid = 1'b0;
   int        phK;
   int        phLen;
   bit        phErr;
   bit        phWrite;
   int        phIdx;
   bit [3:0]  phLanes;

   function automatic bit expReady();
      return !phValid || (phK == phLen - 1);
   endfunction

   function automatic bit expResp();
      return phValid && phErr;
   endfunction

   function automatic bit [31:0] expData();
      if (phValid && (phK == phLen - 1) && !phWrite && !phErr)
         return modelMem[phIdx];
      return 32'h0;
   endfunction

   // Advance the model one bus cycle. A phase lasts wait_cfg+1 cycles, or 2
   // for an error, and the completing cycle may accept the next address.
   initial begin : model
      bit          readyNow;
      int unsigned word;
      int unsigned sz;
      int unsigned nb;
      int unsigned off;
      forever begin
         @(posedge HCLK or negedge HRESETn);
         if (!HRESETn) begin
            phValid = 1'b0;
         end else begin
            readyNow = expReady();
            if (phValid) begin
               if (phK == phLen - 1) begin
                  if (phWrite && !phErr) begin
                     for (int b = 0; b < 4; b++)
                        if (phLanes[b]) modelMem[phIdx][8*b +: 8] = HWDATA[8*b +: 8];
                  end
                  phValid = 1'b0;
               end else begin
                  phK = phK + 1;
               end
            end
            if (readyNow && HSEL && HTRANS[1]) begin
               word    = HADDR / 4;
               sz      = 32'(HSIZE);
               phErr   = ERR_EN && ((word >= MEM_WORDS) || (sz > 2));
               if (sz > 2) sz = 2;
               nb      = 32'd1 << sz;
               off     = ((HADDR % 4) / nb) * nb;
               phLanes = 4'(((32'd1 << nb) - 1) << off);
               phIdx   = int'(word % MEM_WORDS);
               phLen   = phErr ? 2 : int'(wait_cfg) + 1;
               phWrite = HWRITE;
               phK     = 0;
               phValid = 1'b1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   initial begin : compare
      forever begin
         @(negedge HCLK);
         #1;
         checkOutput("model_HREADYOUT", 32'(HREADYOUT), 32'(expReady()));
         checkOutput("model_HRESP", 32'(HRESP), 32'(expResp()));
         checkOutput("model_HRDATA", HRDATA, expData());
      end
   end

   // ---------------- stimulus ----------------
   task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [31:0] addr, input logic [2:0] size,
                                input logic [3:0] wcfg, input logic [31:0] wdata);
      HSEL     = sel;
      HTRANS   = trans;
      HWRITE   = wr;
      HADDR    = addr;
      HSIZE    = size;
      wait_cfg = wcfg;
      HWDATA   = wdata;
   endtask

   task automatic cycle();
      @(posedge HCLK);
      @(negedge HCLK);
   endtask

   initial begin : main
      HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      #1;
      checkOutput("reset_HREADYOUT", 32'(HREADYOUT), 32'h1);
      checkOutput("reset_HRESP", 32'(HRESP), 32'h0);
      checkOutput("reset_HRDATA", HRDATA, 32'h0);
      @(negedge HCLK);
      HRESETn = 1'b1;

      // Fill every word with 0xC0DE0000 | index, pipelined back-to-back.
      for (int i = 0; i <= MEM_WORDS; i++) begin
         applyStimulus(i < MEM_WORDS, (i < MEM_WORDS) ? 2'd2 : 2'd0, 1'b1, 32'(i * 4), 3'd2,
                       4'd0, (i > 0) ? (32'hC0DE0000 | 32'(i - 1)) : 32'h0);
         cycle();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      cycle();

      // Word write then read of 0x10, each with a single-cycle data phase.
      applyStimulus(1, 2'd2, 1, 32'h10, 3'd2, 4'd0, 32'h0);
      cycle();
      applyStimulus(1, 2'd2, 0, 32'h10, 3'd2, 4'd0, 32'hDEADBEEF);
      checkOutput("wr10_ready", 32'(HREADYOUT), 32'h1);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("rd10_ready", 32'(HREADYOUT), 32'h1);
      checkOutput("rd10_data", HRDATA, 32'hDEADBEEF);
      checkOutput("rd10_resp", 32'(HRESP), 32'h0);
      cycle();

      // Read 0x20 with three wait states; wait_cfg changes mid-wait.
      applyStimulus(1, 2'd2, 0, 32'h20, 3'd2, 4'd3, 32'h0);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("rd20_wait", 32'(HREADYOUT), 32'h0);
         cycle();
      end
      checkOutput("rd20_ready", 32'(HREADYOUT), 32'h1);
      checkOutput("rd20_data", HRDATA, 32'hC0DE0008);
      checkOutput("rd20_resp", 32'(HRESP), 32'h0);
      cycle();

      // Byte write of 0xAA to lane 3 over 0x11223344; other lanes carry junk.
      applyStimulus(1, 2'd2, 1, 32'h10, 3'd2, 4'd0, 32'h0);
      cycle();
      applyStimulus(1, 2'd2, 1, 32'h13, 3'd0, 4'd0, 32'h11223344);
      cycle();
      applyStimulus(1, 2'd2, 0, 32'h10, 3'd2, 4'd0, 32'hAA555555);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("byte_data", HRDATA, 32'hAA223344);
      cycle();

      // Back-to-back write then read of address 0.
      applyStimulus(1, 2'd2, 1, 32'h0, 3'd2, 4'd0, 32'h0);
      cycle();
      applyStimulus(1, 2'd2, 0, 32'h0, 3'd2, 4'd0, 32'h5A5A1234);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("b2b_ready", 32'(HREADYOUT), 32'h1);
      checkOutput("b2b_data", HRDATA, 32'h5A5A1234);
      cycle();

      // Write to 0x400, one word past the end of memory.
      applyStimulus(1, 2'd2, 1, 32'h400, 3'd2, 4'd0, 32'h0);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0BADF00D);
`ifdef AHB_SUB_ERR_RESP_EN
      checkOutput("err1_ready", 32'(HREADYOUT), 32'h0);
      checkOutput("err1_resp", 32'(HRESP), 32'h1);
      cycle();
      checkOutput("err2_ready", 32'(HREADYOUT), 32'h1);
      checkOutput("err2_resp", 32'(HRESP), 32'h1);
      cycle();
`else
      checkOutput("wrap_ready", 32'(HREADYOUT), 32'h1);
      checkOutput("wrap_resp", 32'(HRESP), 32'h0);
      cycle();
`endif
      applyStimulus(1, 2'd2, 0, 32'h0, 3'd2, 4'd0, 32'h0);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("w400_word0", HRDATA, ERR_EN ? 32'h5A5A1234 : 32'h0BADF00D);
      cycle();

      // Reset during the second of four wait states of a write to 0x30.
      applyStimulus(1, 2'd2, 1, 32'h30, 3'd2, 4'd4, 32'h0);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 32'hFFFFFFFF);
      checkOutput("rst_wait1", 32'(HREADYOUT), 32'h0);
      cycle();
      checkOutput("rst_wait2", 32'(HREADYOUT), 32'h0);
      HRESETn = 1'b0;
      #1;
      checkOutput("rst_ready", 32'(HREADYOUT), 32'h1);
      checkOutput("rst_resp", 32'(HRESP), 32'h0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      applyStimulus(1, 2'd2, 0, 32'h30, 3'd2, 4'd0, 32'h0);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("rst_word30", HRDATA, 32'hC0DE000C);
      cycle();

      // Randomized traffic, including occasional single-cycle reset pulses.
      for (int c = 0; c < 1500; c++) begin
         int unsigned word;
         word    = ($urandom % 10 < 9) ? ($urandom % 16) : ($urandom % 512);
         HRESETn = ($urandom % 150 == 0) ? 1'b0 : 1'b1;
         applyStimulus($urandom % 8 != 0, 2'($urandom % 4), 1'($urandom % 2),
                       word * 4 + ($urandom % 4), 3'($urandom % 4),
                       ($urandom % 3 == 0) ? 4'($urandom % 5) : 4'd0, $urandom);
         cycle();
      end
      HRESETn = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (8) cycle();

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
